// File: rtl/renode_axi_mem_subordinate.sv
// AXI4 subordinate memory model driven by the Renode manager bundle.
// Services FIXED/INCR/WRAP bursts, narrow transfers and byte strobes.
// Ports:
//   clk, rst                      clock, async active-high reset
//   aw*/awvalid/awready           write address channel
//   wdata/wstrb/wlast/wvalid/wready  write data channel
//   bid/bresp/bvalid/bready       write response channel
//   ar*/arvalid/arready           read address channel
//   rid/rdata/rresp/rlast/rvalid/rready  read data channel
module renode_axi_mem_subordinate #(
   parameter int AddressWidth       = 32,
   parameter int DataWidth          = 32,
   parameter int TransactionIdWidth = 8,
   parameter int MemDepth           = 1024,
   parameter logic [AddressWidth-1:0] BaseAddress = '0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [TransactionIdWidth-1:0] awid,
   input  logic [AddressWidth-1:0]       awaddr,
   input  logic [7:0]                    awlen,
   input  logic [2:0]                    awsize,
   input  logic [1:0]                    awburst,
   input  logic                          awlock,
   input  logic [3:0]                    awcache,
   input  logic [2:0]                    awprot,
   input  logic                          awvalid,
   output logic                          awready,
   input  logic [DataWidth-1:0]          wdata,
   input  logic [DataWidth/8-1:0]        wstrb,
   input  logic                          wlast,
   input  logic                          wvalid,
   output logic                          wready,
   output logic [TransactionIdWidth-1:0] bid,
   output logic [1:0]                    bresp,
   output logic                          bvalid,
   input  logic                          bready,
   input  logic [TransactionIdWidth-1:0] arid,
   input  logic [AddressWidth-1:0]       araddr,
   input  logic [7:0]                    arlen,
   input  logic [2:0]                    arsize,
   input  logic [1:0]                    arburst,
   input  logic                          arlock,
   input  logic [3:0]                    arcache,
   input  logic [2:0]                    arprot,
   input  logic                          arvalid,
   output logic                          arready,
   output logic [TransactionIdWidth-1:0] rid,
   output logic [DataWidth-1:0]          rdata,
   output logic [1:0]                    rresp,
   output logic                          rlast,
   output logic                          rvalid,
   input  logic                          rready
);

   localparam int SW = DataWidth / 8;
   localparam int BW = $clog2(SW);
   localparam int IW = $clog2(MemDepth);
   localparam logic [63:0] SPAN = 64'(MemDepth) * 64'(SW);

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
   typedef enum logic {R_IDLE, R_DATA} rstate_t;

   function automatic logic req_bad(
      input logic [AddressWidth-1:0] a,
      input logic [7:0]              len,
      input logic [2:0]              size,
      input logic [1:0]              burst
   );
      logic [AddressWidth-1:0] off;
      logic                    wrap_ok;
      off = a - BaseAddress;
      wrap_ok = (len == 8'd1) || (len == 8'd3) ||
                (len == 8'd7) || (len == 8'd15);
      return (size > 3'(BW)) || (burst == 2'b11) ||
             (burst == 2'b10 && !wrap_ok) ||
             (a < BaseAddress) || (64'(off) >= SPAN);
   endfunction

   // WRAP keeps the upper bits of the aligned window and lets only
   // the in-window offset roll over.
   function automatic logic [AddressWidth-1:0] next_addr(
      input logic [AddressWidth-1:0] a,
      input logic [7:0]              len,
      input logic [2:0]              size,
      input logic [1:0]              burst
   );
      logic [AddressWidth-1:0] step;
      logic [AddressWidth-1:0] inc;
      logic [AddressWidth-1:0] win;
      logic [AddressWidth-1:0] mask;
      step = AddressWidth'(1) << size;
      inc  = a + step;
      win  = (AddressWidth'(len) + AddressWidth'(1)) << size;
      mask = win - AddressWidth'(1);
      case (burst)
         2'b00:   return a;
         2'b10:   return (a & ~mask) | (inc & mask);
         default: return inc;
      endcase
   endfunction

   function automatic logic [IW-1:0] word_idx(
      input logic [AddressWidth-1:0] a
   );
      logic [AddressWidth-1:0] off;
      off = a - BaseAddress;
      return IW'(off >> BW);
   endfunction

   logic [DataWidth-1:0] r_mem [MemDepth];

   // Holds the ready outputs low for the first cycle after release.
   logic r_up;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_up <= 1'b0;
      else     r_up <= 1'b1;
   end

   // ---------------- write path ----------------
   wstate_t                   r_wst;
   wstate_t                   w_wst_nxt;
   logic [TransactionIdWidth-1:0] r_w_id;
   logic [AddressWidth-1:0]   r_w_addr;
   logic [7:0]                r_w_len;
   logic [2:0]                r_w_size;
   logic [1:0]                r_w_burst;
   logic [8:0]                r_w_cnt;
   logic                      r_w_err;
   logic                      r_w_bad;
   logic                      w_aw_hs;
   logic                      w_w_hs;
   logic                      w_b_hs;
   logic                      w_w_en;
   logic                      w_aw_bad;
   logic [IW-1:0]             w_w_idx;

   assign w_aw_hs  = awvalid && awready;
   assign w_w_hs   = wvalid && wready;
   assign w_b_hs   = bvalid && bready;
   assign w_aw_bad = req_bad(awaddr, awlen, awsize, awburst);
   assign w_w_idx  = word_idx(r_w_addr);
   assign w_w_en   = w_w_hs && !r_w_bad &&
                     (r_w_cnt <= {1'b0, r_w_len});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_wst <= W_IDLE;
      else     r_wst <= w_wst_nxt;
   end

   always_comb begin
      w_wst_nxt = r_wst;
      case (r_wst)
         W_IDLE:  if (w_aw_hs) w_wst_nxt = W_DATA;
         W_DATA:  if (w_w_hs && wlast) w_wst_nxt = W_RESP;
         W_RESP:  if (w_b_hs) w_wst_nxt = W_IDLE;
         default: w_wst_nxt = W_IDLE;
      endcase
   end

   always_comb begin
      awready = r_up && (r_wst == W_IDLE);
      wready  = (r_wst == W_DATA);
      bvalid  = (r_wst == W_RESP);
      bid     = r_w_id;
      bresp   = (bvalid && r_w_err) ? 2'b10 : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_id    <= '0;
         r_w_addr  <= '0;
         r_w_len   <= '0;
         r_w_size  <= '0;
         r_w_burst <= '0;
         r_w_cnt   <= '0;
         r_w_err   <= 1'b0;
         r_w_bad   <= 1'b0;
      end else if (w_aw_hs) begin
         r_w_id    <= awid;
         r_w_addr  <= awaddr;
         r_w_len   <= awlen;
         r_w_size  <= awsize;
         r_w_burst <= awburst;
         r_w_cnt   <= '0;
         r_w_err   <= w_aw_bad;
         r_w_bad   <= w_aw_bad;
      end else if (w_w_hs) begin
         r_w_addr <= next_addr(r_w_addr, r_w_len,
                               r_w_size, r_w_burst);
         // Saturate so overlong bursts never alias back into range.
         if (!r_w_cnt[8]) r_w_cnt <= r_w_cnt + 9'd1;
         if (wlast != (r_w_cnt == {1'b0, r_w_len}))
            r_w_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_w_en) begin
         for (int i = 0; i < SW; i++) begin
            if (wstrb[i])
               r_mem[w_w_idx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // ---------------- read path ----------------
   rstate_t                   r_rstate;
   rstate_t                   w_rstate_nxt;
   logic [TransactionIdWidth-1:0] r_r_id;
   logic [AddressWidth-1:0]   r_r_addr;
   logic [7:0]                r_r_len;
   logic [2:0]                r_r_size;
   logic [1:0]                r_r_burst;
   logic [7:0]                r_r_cnt;
   logic                      r_r_err;
   logic [DataWidth-1:0]      r_rdata;
   logic                      w_ar_hs;
   logic                      w_r_hs;
   logic                      w_ar_bad;
   logic [AddressWidth-1:0]   w_r_nxt;

   assign w_ar_hs  = arvalid && arready;
   assign w_r_hs   = rvalid && rready;
   assign w_ar_bad = req_bad(araddr, arlen, arsize, arburst);
   assign w_r_nxt  = next_addr(r_r_addr, r_r_len,
                               r_r_size, r_r_burst);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rstate <= R_IDLE;
      else     r_rstate <= w_rstate_nxt;
   end

   always_comb begin
      w_rstate_nxt = r_rstate;
      case (r_rstate)
         R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
         R_DATA:  if (w_r_hs && rlast) w_rstate_nxt = R_IDLE;
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_comb begin
      arready = r_up && (r_rstate == R_IDLE);
      rvalid  = (r_rstate == R_DATA);
      rlast   = rvalid && (r_r_cnt == r_r_len);
      rresp   = (rvalid && r_r_err) ? 2'b10 : 2'b00;
      rid     = r_r_id;
      rdata   = r_rdata;
   end

   // rdata is fetched one beat ahead so a held rready streams at
   // one beat per cycle; a same-cycle write is seen next access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_r_id    <= '0;
         r_r_addr  <= '0;
         r_r_len   <= '0;
         r_r_size  <= '0;
         r_r_burst <= '0;
         r_r_cnt   <= '0;
         r_r_err   <= 1'b0;
         r_rdata   <= '0;
      end else if (w_ar_hs) begin
         r_r_id    <= arid;
         r_r_addr  <= araddr;
         r_r_len   <= arlen;
         r_r_size  <= arsize;
         r_r_burst <= arburst;
         r_r_cnt   <= '0;
         r_r_err   <= w_ar_bad;
         r_rdata   <= w_ar_bad ? '0 : r_mem[word_idx(araddr)];
      end else if (w_r_hs && !rlast) begin
         r_r_addr <= w_r_nxt;
         r_r_cnt  <= r_r_cnt + 8'd1;
         r_rdata  <= r_r_err ? '0 : r_mem[word_idx(w_r_nxt)];
      end
   end

   // Lock, cache and protection attributes have no effect here.
   logic w_unused;
   assign w_unused = ^{awlock, awcache, awprot,
                       arlock, arcache, arprot};

endmodule

// File: tb/tb_renode_axi_mem_subordinate.sv
// Randomized scoreboard bench for renode_axi_mem_subordinate.
// Expected B/R responses are queued by stimulus and popped by a monitor.
module tb_renode_axi_mem_subordinate;
   localparam int DEPTH = 1024;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0]  awid, arid, bid, rid;
   logic [31:0] awaddr, araddr, wdata, rdata;
   logic [7:0]  awlen, arlen;
   logic [2:0]  awsize, arsize, awprot, arprot;
   logic [1:0]  awburst, arburst, bresp, rresp;
   logic [3:0]  awcache, arcache, wstrb;
   logic awlock, arlock, awvalid, awready, wlast, wvalid, wready;
   logic bvalid, bready, arvalid, arready, rlast, rvalid, rready;

   renode_axi_mem_subordinate #(
      .AddressWidth(32), .DataWidth(32), .TransactionIdWidth(8),
      .MemDepth(DEPTH), .BaseAddress(32'h0)
   ) dut (
      .clk(clk), .rst(rst),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
      .awburst(awburst), .awlock(awlock), .awcache(awcache),
      .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
      .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
      .bready(bready), .arid(arid), .araddr(araddr), .arlen(arlen),
      .arsize(arsize), .arburst(arburst), .arlock(arlock),
      .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
      .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
      .rlast(rlast), .rvalid(rvalid), .rready(rready)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", nm, got, exp);
      end
   endtask

   task automatic fail_evt(input string nm);
      checks++;
      failures++;
      $display("FAIL %s got=event exp=none", nm);
   endtask

   typedef struct { logic [7:0] id; logic [1:0] resp; } bexp_t;
   typedef struct {
      logic [31:0] data; logic [1:0] resp; logic last; logic [7:0] id;
   } rexp_t;

   bexp_t bq[$];
   rexp_t rq[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] wd [256];
   logic [3:0]  ws [256];
   int rr_mode = 0;

   function automatic bit req_err(input logic [31:0] a,
      input logic [7:0] len, input logic [2:0] sz, input logic [1:0] bu);
      bit wrap_ok;
      wrap_ok = (len == 1) || (len == 3) || (len == 7) || (len == 15);
      return (sz > 2) || (bu == 3) || (bu == 2 && !wrap_ok) ||
             (a >= DEPTH * 4);
   endfunction

   function automatic logic [31:0] beat_addr(input logic [31:0] s,
      input int k, input logic [2:0] sz, input logic [7:0] len,
      input logic [1:0] bu);
      longint sa, step, win, base;
      sa = longint'(s);
      step = longint'(1) << sz;
      win = (longint'(len) + 1) * step;
      if (bu == 0) return s;
      if (bu == 2) begin
         base = sa - (sa % win);
         return 32'(base + ((sa - base) + k * step) % win);
      end
      return 32'(sa + k * step);
   endfunction

   function automatic int widx(input logic [31:0] a);
      return int'((a >> 2) % DEPTH);
   endfunction

   // ready drivers
   initial begin
      bready = 1'b0;
      rready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bready = ($urandom_range(0, 3) != 0);
         if (rr_mode == 0)      rready = 1'b1;
         else if (rr_mode == 1) rready = !rready;
         else                   rready = ($urandom_range(0, 2) != 0);
      end
   end

   // monitor / scoreboard
   initial begin
      bexp_t be;
      rexp_t re;
      logic [34:0] held;
      bit stalled;
      stalled = 0;
      held = '0;
      forever begin
         @(negedge clk);
         if (bvalid && bready) begin
            if (bq.size() == 0) fail_evt("b_unexpected");
            else begin
               be = bq.pop_front();
               check("bid", 64'(bid), 64'(be.id));
               check("bresp", 64'(bresp), 64'(be.resp));
            end
         end
         if (rvalid && rready) begin
            stalled = 0;
            if (rq.size() == 0) fail_evt("r_unexpected");
            else begin
               re = rq.pop_front();
               check("rdata", 64'(rdata), 64'(re.data));
               check("rresp", 64'(rresp), 64'(re.resp));
               check("rlast", 64'(rlast), 64'(re.last));
               check("rid", 64'(rid), 64'(re.id));
            end
         end else if (rvalid) begin
            if (stalled)
               check("r_stall_stable", 64'({rdata, rresp, rlast}),
                     64'(held));
            held = {rdata, rresp, rlast};
            stalled = 1;
         end else stalled = 0;
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] sz, input logic [1:0] bu, input int nb,
      input logic [7:0] id);
      bit bad;
      bexp_t e;
      int n, idx;
      bad = req_err(a, len, sz, bu);
      if (!bad) begin
         for (int k = 0; k < nb && k <= int'(len); k++) begin
            idx = widx(beat_addr(a, k, sz, len, bu));
            for (int b = 0; b < 4; b++)
               if (ws[k][b]) ref_mem[idx][8*b +: 8] = wd[k][8*b +: 8];
         end
      end
      e.id = id;
      e.resp = (bad || nb != int'(len) + 1) ? 2'b10 : 2'b00;
      bq.push_back(e);
      @(posedge clk);
      #1;
      awvalid = 1; awid = id; awaddr = a; awlen = len;
      awsize = sz; awburst = bu;
      awlock = 1'($urandom_range(0, 1));
      n = 0;
      @(negedge clk);
      while (!awready && n < 100) begin @(negedge clk); n++; end
      if (!awready) fail_evt("aw_timeout");
      @(posedge clk);
      #1;
      awvalid = 0;
      for (int k = 0; k < nb; k++) begin
         wvalid = 1; wdata = wd[k]; wstrb = ws[k]; wlast = (k == nb - 1);
         n = 0;
         @(negedge clk);
         while (!wready && n < 100) begin @(negedge clk); n++; end
         if (!wready) fail_evt("w_timeout");
         @(posedge clk);
         #1;
      end
      wvalid = 0;
      wlast = 0;
      n = 0;
      while (bq.size() != 0 && n < 100) begin @(posedge clk); n++; end
      if (bq.size() != 0) begin fail_evt("b_timeout"); bq.delete(); end
   endtask

   task automatic push_read(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] id);
      bit bad;
      rexp_t e;
      bad = req_err(a, len, sz, bu);
      for (int k = 0; k <= int'(len); k++) begin
         e.data = bad ? 32'h0 : ref_mem[widx(beat_addr(a, k, sz, len, bu))];
         e.resp = bad ? 2'b10 : 2'b00;
         e.last = (k == int'(len));
         e.id = id;
         rq.push_back(e);
      end
   endtask

   task automatic issue_ar(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] id);
      int n;
      @(posedge clk);
      #1;
      arvalid = 1; arid = id; araddr = a; arlen = len;
      arsize = sz; arburst = bu;
      n = 0;
      @(negedge clk);
      while (!arready && n < 100) begin @(negedge clk); n++; end
      if (!arready) fail_evt("ar_timeout");
      @(posedge clk);
      #1;
      arvalid = 0;
      check("r_first_valid", 64'(rvalid), 64'd1);
   endtask

   task automatic do_read(input logic [31:0] a, input logic [7:0] len,
      input logic [2:0] sz, input logic [1:0] bu, input logic [7:0] id,
      output int cyc);
      push_read(a, len, sz, bu, id);
      issue_ar(a, len, sz, bu, id);
      cyc = 0;
      while (rq.size() != 0 && cyc < 800) begin @(posedge clk); cyc++; end
      if (rq.size() != 0) begin fail_evt("r_timeout"); rq.delete(); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nb;
      logic [31:0] a;
      logic [7:0] len;
      logic [2:0] sz;
      logic [1:0] bu;
      awvalid = 0; awid = 0; awaddr = 0; awlen = 0; awsize = 0;
      awburst = 0; awlock = 0; awcache = 0; awprot = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0;
      arvalid = 0; arid = 0; araddr = 0; arlen = 0; arsize = 0;
      arburst = 0; arlock = 0; arcache = 0; arprot = 0;
      #2;
      check("reset_outputs", 64'({awready, wready, bvalid, arready,
            rvalid, rlast, bresp, rresp, bid, rid}), 64'd0);
      check("reset_rdata", 64'(rdata), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      check("awready_pre_clk", 64'(awready), 64'd0);
      @(posedge clk);
      #1;
      check("ready_after_rel", 64'({awready, arready}), 64'b11);

      // fill memory so every random read has a known reference
      for (int blk = 0; blk < 4; blk++) begin
         for (int k = 0; k < 256; k++) begin
            wd[k] = $urandom;
            ws[k] = 4'hF;
         end
         do_write(32'(blk * 1024), 8'd255, 3'd2, 2'b01, 256, 8'(blk));
      end

      // single write/read
      wd[0] = 32'hDEADBEEF; ws[0] = 4'hF;
      do_write(32'h10, 8'd0, 3'd2, 2'b01, 1, 8'h5A);
      do_read(32'h10, 8'd0, 3'd2, 2'b01, 8'hA5, cyc);

      // strobes -> 0x11BB33DD
      wd[0] = 32'h11223344; ws[0] = 4'hF;
      do_write(32'h20, 8'd0, 3'd2, 2'b01, 1, 8'h01);
      wd[0] = 32'hAABBCCDD; ws[0] = 4'b0101;
      do_write(32'h20, 8'd0, 3'd2, 2'b01, 1, 8'h02);
      do_read(32'h20, 8'd0, 3'd2, 2'b01, 8'h03, cyc);

      // INCR len 3, back-to-back then stalled
      for (int k = 0; k < 4; k++) begin wd[k] = 32'(k + 1); ws[k] = 4'hF; end
      do_write(32'h40, 8'd3, 3'd2, 2'b01, 4, 8'h10);
      rr_mode = 0;
      do_read(32'h40, 8'd3, 3'd2, 2'b01, 8'h11, cyc);
      check("incr_beats_cycles", 64'(cyc), 64'd4);
      rr_mode = 1;
      do_read(32'h40, 8'd3, 3'd2, 2'b01, 8'h12, cyc);

      // WRAP
      for (int k = 0; k < 4; k++) begin
         wd[k] = 32'h100 + 32'(k); ws[k] = 4'hF;
      end
      do_write(32'h30, 8'd3, 3'd2, 2'b01, 4, 8'h20);
      do_read(32'h38, 8'd3, 3'd2, 2'b10, 8'h21, cyc);
      for (int k = 0; k < 3; k++) begin wd[k] = 32'hBAD0; ws[k] = 4'hF; end
      do_write(32'h30, 8'd2, 3'd2, 2'b10, 3, 8'h22);
      do_read(32'h30, 8'd3, 3'd2, 2'b01, 8'h23, cyc);

      // protocol errors
      for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
      do_write(32'h80, 8'd3, 3'd2, 2'b01, 2, 8'h30);
      do_read(32'h80, 8'd3, 3'd2, 2'b01, 8'h31, cyc);
      do_read(32'h40, 8'd3, 3'd3, 2'b01, 8'h32, cyc);

      // reset mid-burst
      rr_mode = 0;
      push_read(32'h100, 8'd7, 3'd2, 2'b01, 8'h40);
      issue_ar(32'h100, 8'd7, 3'd2, 2'b01, 8'h40);
      @(posedge clk);
      #1;
      rst = 1;
      rq.delete();
      #1;
      check("rst_mid_outputs", 64'({rvalid, arready, awready}), 64'd0);
      @(posedge clk);
      #1;
      rst = 0;
      @(posedge clk);
      #1;
      check("ready_after_rst2", 64'({awready, arready}), 64'b11);
      do_read(32'h100, 8'd7, 3'd2, 2'b01, 8'h41, cyc);
      wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
      do_write(32'h104, 8'd0, 3'd2, 2'b00, 1, 8'h42);
      do_read(32'h104, 8'd0, 3'd2, 2'b00, 8'h43, cyc);

      // randomized traffic
      rr_mode = 2;
      for (int i = 0; i < 80; i++) begin
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 255);
         else a = 32'($urandom_range(0, 4095));
         case ($urandom_range(0, 9))
            0, 1, 2: bu = 2'b01;
            3, 4:    bu = 2'b00;
            9:       bu = 2'b11;
            default: bu = 2'b10;
         endcase
         sz = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         if (bu == 2'b10) begin
            case ($urandom_range(0, 4))
               0: len = 8'd1;
               1: len = 8'd3;
               2: len = 8'd7;
               3: len = 8'd15;
               default: len = 8'd2;
            endcase
         end else len = 8'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 1) begin
            nb = int'(len) + 1;
            if ($urandom_range(0, 9) == 0) nb = $urandom_range(1, int'(len) + 3);
            for (int k = 0; k < nb; k++) begin
               wd[k] = $urandom;
               ws[k] = 4'($urandom_range(0, 15));
            end
            do_write(a, len, sz, bu, nb, 8'($urandom_range(0, 255)));
         end else begin
            do_read(a, len, sz, bu, 8'($urandom_range(0, 255)), cyc);
         end
      end

      repeat (4) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/renode_axi_mem_subordinate.md
Name: renode_axi_mem_subordinate

Overview:
- AXI4 subordinate memory model that sits directly downstream of the Renode AXI interface bundle.
- Consumes Renode-driven manager transactions and services them from an internal word array.
- Supports FIXED, INCR and WRAP bursts, narrow transfers and byte strobes.
- One outstanding transaction per direction; the read and write paths are independent.

Parameters:
AddressWidth, 32, width of awaddr/araddr
DataWidth, 32, data bus width; must be 8/16/32/64; StrobeWidth = DataWidth/8
TransactionIdWidth, 8, width of all ID signals
MemDepth, 1024, number of DataWidth-bit words; power of two
BaseAddress, 0, byte address of word 0; aligned to MemDepth*StrobeWidth

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
awid/awaddr/awlen/awsize/awburst  input  TransactionIdWidth/AddressWidth/8/3/2  write address channel
awlock/awcache/awprot  input  1/4/3  accepted and ignored
awvalid input 1; awready output 1
wdata/wstrb/wlast/wvalid  input  DataWidth/StrobeWidth/1/1; wready output 1
bid/bresp/bvalid  output  TransactionIdWidth/2/1; bready input 1
arid/araddr/arlen/arsize/arburst  input  as the aw* signals
arlock/arcache/arprot  input  ignored
arvalid input 1; arready output 1
rid/rdata/rresp/rlast/rvalid  output  TransactionIdWidth/DataWidth/2/1/1; rready input 1

Behaviour:
- Reset (async assert, sync release):
  - All outputs are 0: awready, wready, bvalid, arready, rvalid, rlast, bresp, rresp, bid, rid, rdata.
  - Memory contents are not reset.
  - Reset mid-burst aborts the transaction immediately; no B or R is issued for it.
- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1 from the first clk after reset release. AW handshake latches id/addr/len/size/burst, clears the beat count and the error flag, drops awready and enters W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes with wstrb=1 to word ((addr-BaseAddress)>>log2(StrobeWidth)) mod MemDepth, then advances addr.
  - W_DATA exits only on a handshake with wlast=1. If wlast does not coincide with beat awlen (0-based), set error. Beats beyond awlen are not written.
  - W_RESP: bvalid=1, bid=latched id, bresp = error ? 2'b10 (SLVERR) : 2'b00 (OKAY). The B handshake returns to W_IDLE and reasserts awready on the next cycle.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. The AR handshake latches the request.
  - The next cycle: rvalid=1, rdata = word at the first beat address (registered read), rid = latched id, rlast = (len==0).
  - Each R handshake advances addr and loads the next beat's rdata in the same cycle, so back-to-back beats run at 1 beat/cycle when rready is held high.
  - rdata, rresp and rlast stay stable while rvalid=1 and rready=0.
  - The R handshake with rlast=1 returns to R_IDLE; arready reasserts the next cycle.
- Address advance:
  - FIXED (2'b00): unchanged.
  - INCR (2'b01): addr + 2**size.
  - WRAP (2'b10): addr + 2**size, wrapped within a (len+1)*2**size byte window aligned to that size.
  - Narrow transfers advance by 2**size even though the data lane is chosen by strobes or by the manager.
  - 4 KB boundary crossing is not checked.
- Error (SLVERR for B; for every beat of R, which is still fully sequenced to len+1 beats with rdata=0):
  - size > log2(StrobeWidth);
  - burst == 2'b11;
  - WRAP with len not in {1,3,7,15};
  - start address outside [BaseAddress, BaseAddress + MemDepth*StrobeWidth).
- Erroneous writes do not modify memory.
- EXOKAY is never returned; lock requests return OKAY.
- Simultaneous read and write of the same word in one cycle: the read returns the old data (read-first); the write takes effect.

Test Plan:
- Single write then read, DataWidth=32: AW addr 0x10, len 0, size 2, INCR; W 0xDEADBEEF, wstrb 4'hF, wlast=1 -> bresp 00, bid echoed. AR to the same address -> rdata 0xDEADBEEF, rlast=1, rresp 00, rvalid exactly 1 cycle after the AR handshake.
- Strobes: write 0x11223344 to 0x20, then 0xAABBCCDD with wstrb 4'b0101 -> read returns 0x11BB33DD.
- INCR len 3 at 0x40 with data 1,2,3,4, rready held high -> 4 consecutive beats 1,2,3,4, rlast on beat 4 only. With rready toggled 1/0, rdata is held stable while stalled.
- WRAP len 3, size 2, start 0x38 -> beats accessed 0x38, 0x3C, 0x30, 0x34. A WRAP with len 2 -> SLVERR, memory unchanged.
- Protocol errors: wlast on beat 1 of a len 3 burst -> bresp 10. Read with size 3 on a 32-bit bus -> 1+len beats with rresp 10 and rdata 0.
- Reset mid-burst: assert rst during beat 2 of an 8-beat read -> rvalid, arready and awready are 0 immediately. After release, awready and arready return to 1 after one clk, and a new transaction completes normally.
